// File: rtl/async_input_filter_if.sv
// ============================================================================
// Module      : async_input_filter_if
// Description : Bundle of the asynchronous inputs and filtered outputs of
//               async_input_filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface async_input_filter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_change;

    // Board side drives the raw lines and consumes the clean levels/strobes
    modport master (
        output async_in,
        input  sync_out,
        input  rise,
        input  fall,
        input  any_change
    );

    modport slave (
        input  async_in,
        output sync_out,
        output rise,
        output fall,
        output any_change
    );
endinterface

`default_nettype wire

// File: rtl/async_input_filter.sv
// ============================================================================
// Module      : async_input_filter
// Description : WIDTH-channel synchroniser with per-channel glitch filter and
//               registered rise/fall/any_change strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_input_filter #(
    parameter int               WIDTH         = 4,
    parameter int               SYNC_STAGES   = 2,
    parameter int               FILTER_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    async_input_filter_if.slave  bus
);

    localparam int               CNT_W     = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] w_upd;
    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic             r_any;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            // Input path is covered by a false-path/no-IOB constraint on r_stg[0]
            (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
            logic [SYNC_STAGES-1:0] r_stg;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_out;
            logic                   r_rise;
            logic                   r_fall;
            logic                   w_s;

            assign w_s      = r_stg[SYNC_STAGES-1];
            assign w_upd[i] = (w_s != r_out) && (r_cnt == C_CNT_MAX);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stg <= {SYNC_STAGES{RESET_VAL[i]}};
                end else begin
                    r_stg <= {r_stg[SYNC_STAGES-2:0], bus.async_in[i]};
                end
            end

            // cnt only advances while the synchronised level disagrees, so it
            // tops out at C_CNT_MAX and any agreeing sample restarts it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_out  <= RESET_VAL[i];
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (w_s == r_out) begin
                        r_cnt <= '0;
                    end else if (w_upd[i]) begin
                        r_out  <= w_s;
                        r_cnt  <= '0;
                        r_rise <= w_s;
                        r_fall <= ~w_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_sync_out[i] = r_out;
            assign w_rise[i]     = r_rise;
            assign w_fall[i]     = r_fall;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_upd;
        end
    end

    assign bus.sync_out   = w_sync_out;
    assign bus.rise       = w_rise;
    assign bus.fall       = w_fall;
    assign bus.any_change = r_any;

endmodule

`default_nettype wire
